mem_access_unit: RTL and testbench

MEM-stage memory access engine, sitting between the EX/MEM pipeline register and the MEM/WB stage. It consumes the registered EX/MEM control and data (MemRead, MemWrite, RegWrite, MemtoReg, ALU result as address, rs2 data, rd, funct3) and issues a valid/ready request to data memory. It waits for load responses, formats load data, and stalls the upstream pipeline while an access is in flight. Non-memory instructions pass through to the registered write-back outputs in one cycle.

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Turns the held EX/MEM
// control/data into a valid/ready memory request, waits for load data,
// formats it, and stalls the front of the pipeline while an access is open.
// Non-memory instructions pass straight through to the write-back registers.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    output logic        stall,
    output logic        req_valid,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    output logic        wb_RegWrite,
    output logic        wb_MemtoReg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    // A limit of zero disables the response timeout.
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic        failed;
    logic [31:0] load_buf;
    logic        mem_op;
    logic        is_write;
    logic        bad;
    logic        timeout_hit;

    // Illegal size/sign encodings and misaligned addresses; bytes never misalign.
    function automatic logic access_bad(input logic [2:0] f3, input logic wr,
                                        input logic [1:0] off);
        logic b;
        case (f3)
            3'b000:  b = 1'b0;
            3'b001:  b = off[0];
            3'b010:  b = (off != 2'b00);
            3'b100:  b = wr;
            3'b101:  b = wr | off[0];
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    // Pick the addressed lane out of the load word and extend it.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0]        lane;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic [31:0]        r;
        lane = word >> {off, 3'b000};
        b8   = lane[7:0];
        h16  = lane[15:0];
        case (f3)
            3'b000:  r = 32'(b8);
            3'b001:  r = 32'(h16);
            3'b100:  r = {24'd0, lane[7:0]};
            3'b101:  r = {16'd0, lane[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Both MemRead and MemWrite set is treated as a read.
    assign mem_op      = MemRead_in | MemWrite_in;
    assign is_write    = MemWrite_in & ~MemRead_in;
    assign bad         = mem_op & access_bad(funct3_in, is_write, alu_result_in[1:0]);
    assign timeout_hit = (TO_LIM != 16'd0) && ((wait_cnt + 16'd1) == TO_LIM);

    // Hold the pipeline while an access is accepted but not yet finished.
    assign stall = rst & (((state == IDLE) & mem_op & ~bad) | (state == REQ) | (state == WAIT));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op && !bad) state_nxt = REQ;
            REQ:     if (req_ready) state_nxt = is_write ? DONE : WAIT;
            WAIT:    if (rsp_valid || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields, driven only in REQ and stable because EX/MEM is held.
    always_comb begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'b0000;
        if (state == REQ) begin
            req_valid = 1'b1;
            req_addr  = {alu_result_in[31:2], 2'b00};
            req_be    = 4'b1111;
            if (is_write) begin
                req_we = 1'b1;
                case (funct3_in[1:0])
                    2'b00: begin
                        req_be    = 4'b0001 << alu_result_in[1:0];
                        req_wdata = {4{rs2_data_in[7:0]}};
                    end
                    2'b01: begin
                        req_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                        req_wdata = {2{rs2_data_in[15:0]}};
                    end
                    default: begin
                        req_be    = 4'b1111;
                        req_wdata = rs2_data_in;
                    end
                endcase
            end
        end
    end

    // Timeout counter, failure flag, fault pulse and load capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 16'd0;
            failed   <= 1'b0;
            fault    <= 1'b0;
            load_buf <= 32'd0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    failed <= 1'b0;
                    if (bad) fault <= 1'b1;
                end
                REQ: if (req_ready) wait_cnt <= 16'd0;
                WAIT: begin
                    if (rsp_valid) begin
                        load_buf <= fmt_load(funct3_in, alu_result_in[1:0], rsp_rdata);
                    end else if (timeout_hit) begin
                        fault  <= 1'b1;
                        failed <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-back registers: pass-through, bubbles while busy, load result in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_RegWrite <= 1'b0;
            wb_MemtoReg <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        wb_RegWrite <= RegWrite_in;
                        wb_MemtoReg <= MemtoReg_in;
                        wb_rd       <= rd_in;
                        wb_data     <= alu_result_in;
                    end else begin
                        wb_RegWrite <= 1'b0;
                    end
                end
                DONE: begin
                    if (MemRead_in && !failed) begin
                        wb_RegWrite <= RegWrite_in;
                        wb_MemtoReg <= MemtoReg_in;
                        wb_rd       <= rd_in;
                        wb_data     <= load_buf;
                    end else begin
                        wb_RegWrite <= 1'b0;
                        wb_data     <= 32'd0;
                    end
                end
                default: wb_RegWrite <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a reference
// model of request formatting, load formatting and expected write-backs.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [31:0] alu_result_in, rs2_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        stall, req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        wb_RegWrite, wb_MemtoReg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t exp_q[$];
    wb_t cmp_e;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
        .rd_in(rd_in), .funct3_in(funct3_in),
        .stall(stall), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: access width in bytes is 2^funct3[1:0].
    function automatic bit m_bad(input logic [2:0] f3, input logic [31:0] addr, input bit wr_only);
        int size;
        size = 1 << f3[1:0];
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (f3[2] && wr_only) return 1'b1;
        return (addr % size) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr, input bit wr_only);
        int size;
        int t;
        if (!wr_only) return 4'hF;
        size = 1 << f3[1:0];
        t = ((1 << size) - 1) << int'(addr % 4);
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2, input bit wr_only);
        if (!wr_only) return 32'd0;
        case (f3[1:0])
            2'd0:    return {24'd0, rs2[7:0]} * 32'h01010101;
            2'd1:    return {16'd0, rs2[15:0]} * 32'h00010001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        longint v;
        int     bits;
        bits = 8 * (1 << f3[1:0]);
        v = longint'(word) >> (8 * (addr % 4));
        if (bits < 32) begin
            v = v % (longint'(1) << bits);
            if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        end
        return v[31:0];
    endfunction

    // Compare process: request fields against the held instruction, write-backs against the queue.
    always @(negedge clk) begin
        if (rst && req_valid) begin
            check("req_addr", req_addr, alu_result_in & 32'hFFFF_FFFC);
            check("req_we", 32'(req_we), 32'(MemWrite_in & ~MemRead_in));
            check("req_be", 32'(req_be), 32'(m_be(funct3_in, alu_result_in, MemWrite_in & ~MemRead_in)));
            check("req_wdata", req_wdata, m_wdata(funct3_in, rs2_data_in, MemWrite_in & ~MemRead_in));
        end
        if (wb_RegWrite) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%08h expected no write-back", wb_rd, wb_data);
            end else begin
                cmp_e = exp_q.pop_front();
                check("wb_rd_model", 32'(wb_rd), 32'(cmp_e.rd));
                check("wb_data_model", wb_data, cmp_e.data);
            end
        end
    end

    task automatic nop();
        RegWrite_in = 1'b0; MemtoReg_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        alu_result_in = 32'd0; rs2_data_in = 32'd0; rd_in = 5'd0; funct3_in = 3'd0;
    endtask

    task automatic alu(input logic m2r, input logic [4:0] rd, input logic [31:0] val);
        wb_t e;
        RegWrite_in = 1'b1; MemtoReg_in = m2r; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        alu_result_in = val; rs2_data_in = 32'h5A5A5A5A; rd_in = rd; funct3_in = 3'b010;
        e.rd = rd; e.data = val;
        exp_q.push_back(e);
        #1;
        check("alu_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("alu_wb_rw", 32'(wb_RegWrite), 32'd1);
        check("alu_wb_m2r", 32'(wb_MemtoReg), 32'(m2r));
        check("alu_wb_rd", 32'(wb_rd), 32'(rd));
        check("alu_wb_data", wb_data, val);
    endtask

    task automatic do_mem(input string name, input logic rd_w, input logic mr, input logic mw,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [4:0] rd, input int rdy_lat, input int rsp_lat,
                          input logic send, input logic [31:0] word,
                          input int x_stall, input int x_rv, input int x_fault,
                          input logic x_wbrw, input logic chk_data, input logic [31:0] x_wbdata,
                          input logic [31:0] x_addr, input logic [3:0] x_be, input logic [31:0] x_wdata);
        int  stall_cnt, rv_cnt, after_hs, fault_cnt;
        bit  hs, finished;
        wb_t e;
        stall_cnt = 0; rv_cnt = 0; after_hs = 0; fault_cnt = 0; hs = 1'b0; finished = 1'b0;
        RegWrite_in = rd_w; MemtoReg_in = mr; MemRead_in = mr; MemWrite_in = mw;
        funct3_in = f3; alu_result_in = addr; rs2_data_in = rs2; rd_in = rd;
        rsp_rdata = word; req_ready = 1'b0; rsp_valid = 1'b0;
        if (mr && rd_w && send && rsp_lat < TO && !m_bad(f3, addr, 1'b0)) begin
            e.rd = rd; e.data = m_load(f3, addr, word);
            exp_q.push_back(e);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fault) fault_cnt++;
            if (hs) after_hs++;
            if (req_valid) begin
                rv_cnt++;
                if (rv_cnt == 1) begin
                    check({name, "_req_addr"}, req_addr, x_addr);
                    check({name, "_req_be"}, 32'(req_be), 32'(x_be));
                    check({name, "_req_wdata"}, req_wdata, x_wdata);
                end
            end
            req_ready = req_valid && (rv_cnt > rdy_lat);
            rsp_valid = send && hs && (after_hs == rsp_lat);
            if (req_ready) hs = 1'b1;
            if (!stall) begin
                finished = 1'b1;
                break;
            end
            stall_cnt++;
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_budget: stall still high after 40 cycles, required release", name);
        end
        @(posedge clk); #1;
        if (fault) fault_cnt++;
        check({name, "_stall_cycles"}, stall_cnt, x_stall);
        check({name, "_req_cycles"}, rv_cnt, x_rv);
        check({name, "_fault"}, fault_cnt, x_fault);
        check({name, "_wb_rw"}, 32'(wb_RegWrite), 32'(x_wbrw));
        if (x_wbrw) begin
            check({name, "_wb_m2r"}, 32'(wb_MemtoReg), 32'd1);
            check({name, "_wb_rd"}, 32'(wb_rd), 32'(rd));
        end
        if (chk_data) check({name, "_wb_data"}, wb_data, x_wbdata);
        nop();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        nop();
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'd0;
        // A valid load sits on the inputs while reset is held.
        RegWrite_in = 1'b1; MemRead_in = 1'b1; funct3_in = 3'b010; alu_result_in = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_we", 32'(req_we), 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
        check("rst_req_wdata", req_wdata, 32'd0);
        check("rst_req_be", 32'(req_be), 32'd0);
        check("rst_wb_rw", 32'(wb_RegWrite), 32'd0);
        check("rst_wb_m2r", 32'(wb_MemtoReg), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        nop();
        @(posedge clk); #1;
        rst = 1'b1;

        alu(1'b0, 5'd5, 32'h0000_1234);
        nop();
        @(posedge clk); #1;
        check("alu_bubble", 32'(wb_RegWrite), 32'd0);
        alu(1'b0, 5'd7, 32'hCAFE_F00D);
        alu(1'b1, 5'd31, 32'hFFFF_FFFF);
        nop();
        @(posedge clk); #1;

        //      name        rw    mr    mw    f3      addr           rs2            rd     rdy rsp snd  word           stl rv flt wbrw  chk   wbdata         xaddr          xbe      xwdata
        do_mem("sb",        1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0,  3,  0,  1'b0, 32'd0,         5,  4, 0,  1'b0, 1'b1, 32'd0,         32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
        do_mem("sh",        1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_BEEF, 5'd0,  0,  0,  1'b0, 32'd0,         2,  1, 0,  1'b0, 1'b1, 32'd0,         32'h0000_0020, 4'b1100, 32'hBEEF_BEEF);
        do_mem("sw",        1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'h89AB_CDEF, 5'd0,  1,  0,  1'b0, 32'd0,         3,  2, 0,  1'b0, 1'b1, 32'd0,         32'h0000_0044, 4'b1111, 32'h89AB_CDEF);
        do_mem("lb",        1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0202, 32'd0,         5'd9,  0,  2,  1'b1, 32'h0080_0000, 4,  1, 0,  1'b1, 1'b1, 32'hFFFF_FF80, 32'h0000_0200, 4'b1111, 32'd0);
        do_mem("lbu",       1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_0202, 32'd0,         5'd10, 0,  2,  1'b1, 32'h0080_0000, 4,  1, 0,  1'b1, 1'b1, 32'h0000_0080, 32'h0000_0200, 4'b1111, 32'd0);
        do_mem("lw",        1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0,         5'd11, 0,  1,  1'b1, 32'hDEAD_BEEF, 3,  1, 0,  1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 4'b1111, 32'd0);
        do_mem("lh",        1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0082, 32'd0,         5'd12, 2,  1,  1'b1, 32'h8001_1234, 5,  3, 0,  1'b1, 1'b1, 32'hFFFF_8001, 32'h0000_0080, 4'b1111, 32'd0);
        do_mem("lhu",       1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0080, 32'd0,         5'd13, 0,  3,  1'b1, 32'h8001_F234, 5,  1, 0,  1'b1, 1'b1, 32'h0000_F234, 32'h0000_0080, 4'b1111, 32'd0);
        do_mem("rw_both",   1'b1, 1'b1, 1'b1, 3'b100, 32'h0000_0001, 32'h5555_5555, 5'd14, 0,  1,  1'b1, 32'h0000_AB00, 3,  1, 0,  1'b1, 1'b1, 32'h0000_00AB, 32'h0000_0000, 4'b1111, 32'd0);
        do_mem("lw_mis",    1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0,         5'd15, 0,  0,  1'b0, 32'd0,         0,  0, 1,  1'b0, 1'b0, 32'd0,         32'd0,         4'b0000, 32'd0);
        do_mem("f3_011",    1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'd0,         5'd15, 0,  0,  1'b0, 32'd0,         0,  0, 1,  1'b0, 1'b0, 32'd0,         32'd0,         4'b0000, 32'd0);
        do_mem("sh_mis",    1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h1111_2222, 5'd0,  0,  0,  1'b0, 32'd0,         0,  0, 1,  1'b0, 1'b0, 32'd0,         32'd0,         4'b0000, 32'd0);
        do_mem("shu_wr",    1'b0, 1'b0, 1'b1, 3'b101, 32'h0000_0000, 32'h3333_4444, 5'd0,  0,  0,  1'b0, 32'd0,         0,  0, 1,  1'b0, 1'b0, 32'd0,         32'd0,         4'b0000, 32'd0);
        do_mem("lw_to",     1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0,         5'd16, 0,  0,  1'b0, 32'd0,         6,  1, 1,  1'b0, 1'b1, 32'd0,         32'h0000_0010, 4'b1111, 32'd0);

        // Reset dropped while a load waits for its response.
        RegWrite_in = 1'b1; MemtoReg_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0;
        funct3_in = 3'b010; alu_result_in = 32'h48; rd_in = 5'd17; rs2_data_in = 32'd0;
        @(negedge clk);
        check("rstw_idle_stall", 32'(stall), 32'd1);
        req_ready = 1'b1;
        @(negedge clk);
        check("rstw_req_valid", 32'(req_valid), 32'd1);
        @(negedge clk);
        req_ready = 1'b0;
        check("rstw_wait_stall", 32'(stall), 32'd1);
        check("rstw_wait_rv", 32'(req_valid), 32'd0);
        #1 rst = 1'b0;
        #1;
        check("rstw_stall", 32'(stall), 32'd0);
        check("rstw_req_valid_off", 32'(req_valid), 32'd0);
        check("rstw_req_addr", req_addr, 32'd0);
        check("rstw_wb_rw", 32'(wb_RegWrite), 32'd0);
        check("rstw_wb_data", wb_data, 32'd0);
        check("rstw_fault", 32'(fault), 32'd0);
        nop();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("stray_stall", 32'(stall), 32'd0);
        check("stray_req_valid", 32'(req_valid), 32'd0);
        check("stray_wb_rw", 32'(wb_RegWrite), 32'd0);
        check("stray_fault", 32'(fault), 32'd0);
        @(posedge clk); #1;
        do_mem("lw_after_rst", 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0048, 32'd0, 5'd17, 0, 1, 1'b1, 32'h0102_0304,
               3, 1, 0, 1'b1, 1'b1, 32'h0102_0304, 32'h0000_0048, 4'b1111, 32'd0);

        check("wb_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
